// File: rtl/uart_prog_loader_pkg.sv
// uart_prog_loader_pkg: frame command codes, address width and state encodings
package uart_prog_loader_pkg;
  localparam logic [7:0] CMD_INST = 8'h49;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_END = 8'h45;
  localparam int UPG_ADR_W = 15;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE} state_t;
  typedef enum logic [1:0] {WAIT_START, START, BITS, STOP} rx_state_t;
endpackage

// File: rtl/uart_prog_loader_rx.sv
// uart_rx_byte: 2-FF synchronized 8N1 receiver with mid-bit sampling
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int BIT_CYC = 78
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  rx_state_t st;
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] nbit;
  logic [7:0] sh;
  logic rx;
  assign rx = sync[1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync <= '1;
      st <= WAIT_START;
      cnt <= '0;
      nbit <= '0;
      sh <= '0;
      byte_o <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx_i};
      byte_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      cnt <= cnt + CW'(1);
      case (st)
        WAIT_START: begin
          cnt <= '0;
          if (sync[2] && !rx) st <= START;
        end
        // a start bit that is high again at half a bit time was a glitch
        START: if (cnt == HALF) begin
          cnt <= '0;
          nbit <= '0;
          st <= rx ? WAIT_START : BITS;
        end
        BITS: if (cnt == LAST) begin
          cnt <= '0;
          sh <= {rx, sh[7:1]};
          nbit <= nbit + 3'd1;
          if (nbit == 3'd7) st <= STOP;
        end
        STOP: if (cnt == LAST) begin
          st <= WAIT_START;
          byte_o <= sh;
          byte_valid_o <= rx;
          frame_err_o <= !rx;
        end
        default: st <= WAIT_START;
      endcase
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses UART load frames into upg_* instruction/data memory writes
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 128_000,
  parameter int WORD_LIMIT  = 16384,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_i,
  output logic                 upg_clk_o,
  output logic                 upg_rst_o,
  output logic                 upg_wen_o,
  output logic [UPG_ADR_W-1:0] upg_adr_o,
  output logic [31:0]          upg_dat_o,
  output logic                 upg_done_o,
  output logic                 err_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] LIMIT = 17'(WORD_LIMIT);
  state_t st;
  logic [7:0] rx_byte, n_lo;
  logic byte_valid, frame_err, target, in_frame, timeout;
  logic [13:0] word_index;
  logic [14:0] n;
  logic [15:0] n_full;
  logic [1:0] nbyte;
  logic [23:0] word;
  logic [TW-1:0] tmo;
  uart_rx_byte #(.BIT_CYC(CLK_HZ / BAUD)) u_rx (
    .clock(clock), .reset_n(reset_n), .rx_i(rx_i),
    .byte_o(rx_byte), .byte_valid_o(byte_valid), .frame_err_o(frame_err)
  );
  assign upg_clk_o = clock;
  assign n_full = {rx_byte, n_lo};
  assign in_frame = st == CNT_LO || st == CNT_HI || st == DATA;
  assign timeout = in_frame && !byte_valid && tmo == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      upg_rst_o <= 1'b1;
      upg_wen_o <= 1'b0;
      upg_adr_o <= '0;
      upg_dat_o <= '0;
      upg_done_o <= 1'b0;
      err_o <= 1'b0;
      target <= 1'b0;
      word_index <= '0;
      n_lo <= '0;
      n <= '0;
      nbyte <= '0;
      word <= '0;
      tmo <= '0;
    end else begin
      upg_wen_o <= 1'b0;
      tmo <= (!in_frame || byte_valid) ? '0 : tmo + TW'(1);
      if (frame_err) err_o <= 1'b1;
      // a stalled frame is abandoned; already written words are kept
      if (timeout) begin
        err_o <= 1'b1;
        st <= IDLE;
      end else if (byte_valid)
        case (st)
          IDLE:
            if (rx_byte == CMD_INST || rx_byte == CMD_DATA) begin
              target <= rx_byte == CMD_DATA;
              word_index <= '0;
              upg_rst_o <= 1'b0;
              st <= CNT_LO;
            end else if (rx_byte == CMD_END) begin
              upg_done_o <= 1'b1;
              upg_rst_o <= 1'b1;
              st <= DONE;
            end else err_o <= 1'b1;
          CNT_LO: begin
            n_lo <= rx_byte;
            st <= CNT_HI;
          end
          CNT_HI:
            if (n_full == '0) st <= IDLE;
            else if ({1'b0, n_full} > LIMIT) begin
              err_o <= 1'b1;
              st <= IDLE;
            end else begin
              n <= n_full[14:0];
              nbyte <= '0;
              st <= DATA;
            end
          DATA: begin
            nbyte <= nbyte + 2'd1;
            if (nbyte == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= {target, word_index};
              upg_dat_o <= {rx_byte, word};
              word_index <= word_index + 14'd1;
              if ({1'b0, word_index} + 15'd1 == n) st <= IDLE;
            end else word <= {rx_byte, word[23:8]};
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: frame-level reference model and directed corner sequences
module tb_uart_prog_loader;
  localparam int BIT = 10;
  logic clk = 1'b0, reset_n = 1'b0, rx = 1'b1;
  logic upg_clk, upg_rst, upg_wen, upg_done, err;
  logic [14:0] upg_adr;
  logic [31:0] upg_dat;
  int vectors = 0, miscompares = 0;
  logic [46:0] got_q[$], exp_q[$];
  typedef struct {
    logic [7:0] cmd;
    int n;
  } frame_t;
  frame_t tbl[6];
  logic [7:0] t1[11] = '{8'h49, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  always #5 clk = ~clk;
  uart_prog_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .WORD_LIMIT(16384), .TIMEOUT_CYC(500)) dut (
    .clock(clk), .reset_n(reset_n), .rx_i(rx), .upg_clk_o(upg_clk), .upg_rst_o(upg_rst),
    .upg_wen_o(upg_wen), .upg_adr_o(upg_adr), .upg_dat_o(upg_dat), .upg_done_o(upg_done), .err_o(err)
  );
  always @(negedge clk) if (upg_wen) got_q.push_back({upg_adr, upg_dat});
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(logic [7:0] b, bit stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      cycles(BIT);
    end
    rx = 1'b1;
    cycles(2 * BIT);
  endtask
  // expected writes follow directly from the frame: word k of target t lands at {t,k}
  task automatic send_frame(logic [7:0] cmd, int n, bit live);
    logic [31:0] w;
    send(cmd);
    send(n[7:0]);
    send(n[15:8]);
    if (n <= 16384)
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        for (int j = 0; j < 4; j++) send(w[8*j+:8]);
        if (live) exp_q.push_back({cmd == 8'h44, 14'(k), w});
      end
  endtask
  task automatic check_writes(string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(name, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    cycles(3);
    reset_n = 1'b1;
    cycles(5);
    got_q.delete();
  endtask
  initial begin
    tbl = '{'{8'h49, 3}, '{8'h44, 2}, '{8'h49, 0}, '{8'h44, 1}, '{8'h49, 4}, '{8'h44, 0}};
    cycles(3);
    chk("rst_upg_rst", upg_rst, 1);
    chk("rst_wen", upg_wen, 0);
    chk("rst_adr", upg_adr, 0);
    chk("rst_dat", upg_dat, 0);
    chk("rst_done", upg_done, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    cycles(5);
    foreach (t1[i]) send(t1[i]);
    exp_q.push_back({15'h0000, 32'h12345678});
    exp_q.push_back({15'h0001, 32'hDEADBEEF});
    check_writes("t1");
    chk("t1_upg_rst", upg_rst, 0);
    chk("t1_err", err, 0);
    foreach (tbl[i]) begin
      send_frame(tbl[i].cmd, tbl[i].n, 1'b1);
      check_writes("tbl");
      chk("tbl_err", err, 0);
      chk("tbl_upg_rst", upg_rst, 0);
    end
    repeat (4) begin
      send_frame($urandom_range(0, 1) ? 8'h44 : 8'h49, $urandom_range(1, 3), 1'b1);
      check_writes("rand");
    end
    chk("rand_err", err, 0);
    send(8'h44); send(8'h01); send(8'h00);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    exp_q.push_back({15'h4000, 32'h00000001});
    send(8'h45);
    check_writes("t2");
    chk("t2_done", upg_done, 1);
    chk("t2_upg_rst", upg_rst, 1);
    send_frame(8'h49, 1, 1'b0);
    check_writes("t2_after_done");
    chk("t2_done_held", upg_done, 1);
    do_reset();
    send_frame(8'h49, 0, 1'b1);
    check_writes("t3_zero");
    chk("t3_zero_err", err, 0);
    send_frame(8'h49, 16'h4101, 1'b1);
    check_writes("t3_big");
    chk("t3_big_err", err, 1);
    send(8'h45);
    chk("t3_idle_done", upg_done, 1);
    do_reset();
    send(8'h49); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    cycles(600);
    chk("t4_timeout_err", err, 1);
    check_writes("t4_timeout");
    send(8'h49); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    exp_q.push_back({15'h0000, 32'h44332211});
    check_writes("t4_resume");
    chk("t4_upg_rst", upg_rst, 0);
    do_reset();
    send(8'h49); send(8'h01); send(8'h00);
    send(8'h99, 1'b0);
    chk("t5_stop_err", err, 1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    exp_q.push_back({15'h0000, 32'h04030201});
    check_writes("t5_word");
    do_reset();
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    chk("t5_glitch_err", err, 0);
    check_writes("t5_glitch");
    send(8'h45);
    chk("t5_glitch_done", upg_done, 1);
    do_reset();
    send_frame(8'h49, 2, 1'b1);
    check_writes("t6_pre");
    chk("t6_pre_adr", upg_adr, 15'h0001);
    send(8'h49); send(8'h01); send(8'h00); send(8'h5A); send(8'hC3);
    rx = 1'b0;
    cycles(35);
    reset_n = 1'b0;
    #1;
    chk("t6_upg_rst", upg_rst, 1);
    chk("t6_wen", upg_wen, 0);
    chk("t6_adr", upg_adr, 0);
    chk("t6_dat", upg_dat, 0);
    chk("t6_done", upg_done, 0);
    chk("t6_err", err, 0);
    rx = 1'b1;
    cycles(3);
    reset_n = 1'b1;
    cycles(60);
    send(8'h45);
    chk("t6_end_done", upg_done, 1);
    check_writes("t6_no_wen");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
